adder_result_checker: RTL and testbench

- Scoreboard stage directly downstream of the 32-bit adder.
- Samples each operand pair and the adder's sum, recomputes the golden sum, and flags mismatches such as injected faults.
- Keeps error statistics and a cycle stamp for the first failure.
- Two-stage pipeline under a small run-control FSM; feeds the test harness status registers.

---
 rtl/adder_result_checker.sv | 182 ++++++++++++++++++
 tb/tb_adder_result_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Scoreboard stage behind the 32-bit adder: recomputes a+b, flags mismatches, keeps statistics.
// Optional first-failure operand capture is built when ADDER_CHECKER_CAPTURE_EN is defined.
module adder_result_checker #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 32,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    output logic             res_valid,
    output logic             res_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic             sticky_err,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_s_q, s1_s_d;
    logic [CNT_W-1:0] s1_stamp_q, s1_stamp_d;

    logic             res_valid_q, res_valid_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] chk_count_q, chk_count_d;
    logic [CNT_W-1:0] first_err_cycle_q, first_err_cycle_d;
    logic             sticky_err_q, sticky_err_d;

    logic             capture;
    logic [WIDTH-1:0] exp_sum;
    logic             mismatch;
    logic             first_mismatch;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d           = state_q;
        cycle_cnt_d       = cycle_cnt_q;
        s1_a_d            = s1_a_q;
        s1_b_d            = s1_b_q;
        s1_s_d            = s1_s_q;
        s1_stamp_d        = s1_stamp_q;
        err_count_d       = err_count_q;
        chk_count_d       = chk_count_q;
        first_err_cycle_d = first_err_cycle_q;

        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

        // Capture is gated by the current state, so a sample beside a start pulse is dropped.
        capture    = in_valid && (state_q == ST_RUN);
        s1_valid_d = capture;
        if (capture) begin
            s1_a_d     = a;
            s1_b_d     = b;
            s1_s_d     = s;
            s1_stamp_d = cycle_cnt_q;
        end

        exp_sum        = s1_a_q + s1_b_q;
        mismatch       = s1_valid_q && (exp_sum != s1_s_q);
        first_mismatch = mismatch && !sticky_err_q;

        res_valid_d  = s1_valid_q;
        res_err_d    = mismatch;
        sticky_err_d = sticky_err_q | mismatch;

        if (s1_valid_q && (chk_count_q != CNT_MAX)) chk_count_d = chk_count_q + CNT_W'(1);
        if (mismatch && (err_count_q != CNT_MAX))   err_count_d = err_count_q + CNT_W'(1);
        if (first_mismatch)                         first_err_cycle_d = s1_stamp_q;

        unique case (state_q)
            ST_IDLE: if (start && !stop) state_d = ST_RUN;
            ST_RUN: begin
                if (HALT_ON_ERR && mismatch) state_d = ST_HALT;
                else if (stop)               state_d = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q           <= ST_IDLE;
            cycle_cnt_q       <= '0;
            s1_valid_q        <= 1'b0;
            s1_a_q            <= '0;
            s1_b_q            <= '0;
            s1_s_q            <= '0;
            s1_stamp_q        <= '0;
            res_valid_q       <= 1'b0;
            res_err_q         <= 1'b0;
            err_count_q       <= '0;
            chk_count_q       <= '0;
            first_err_cycle_q <= '0;
            sticky_err_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cycle_cnt_q       <= cycle_cnt_d;
            s1_valid_q        <= s1_valid_d;
            s1_a_q            <= s1_a_d;
            s1_b_q            <= s1_b_d;
            s1_s_q            <= s1_s_d;
            s1_stamp_q        <= s1_stamp_d;
            res_valid_q       <= res_valid_d;
            res_err_q         <= res_err_d;
            err_count_q       <= err_count_d;
            chk_count_q       <= chk_count_d;
            first_err_cycle_q <= first_err_cycle_d;
            sticky_err_q      <= sticky_err_d;
        end
    end

`ifdef ADDER_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] first_err_a_q, first_err_a_d;
    logic [WIDTH-1:0] first_err_b_q, first_err_b_d;
    logic [WIDTH-1:0] first_err_s_q, first_err_s_d;

    always_comb begin
        first_err_a_d = first_err_a_q;
        first_err_b_d = first_err_b_q;
        first_err_s_d = first_err_s_q;
        if (first_mismatch) begin
            first_err_a_d = s1_a_q;
            first_err_b_d = s1_b_q;
            first_err_s_d = s1_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_err_a_q <= '0;
            first_err_b_q <= '0;
            first_err_s_q <= '0;
        end else begin
            first_err_a_q <= first_err_a_d;
            first_err_b_q <= first_err_b_d;
            first_err_s_q <= first_err_s_d;
        end
    end

    assign first_err_a = first_err_a_q;
    assign first_err_b = first_err_b_q;
    assign first_err_s = first_err_s_q;
`else
    assign first_err_a = '0;
    assign first_err_b = '0;
    assign first_err_s = '0;
`endif

    assign res_valid       = res_valid_q;
    assign res_err         = res_err_q;
    assign err_count       = err_count_q;
    assign chk_count       = chk_count_q;
    assign first_err_cycle = first_err_cycle_q;
    assign sticky_err      = sticky_err_q;
    assign state           = state_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: two instances (keep-checking and halt-on-error) share one
// stimulus stream and are compared every cycle against a per-instance behavioural model.
module tb_adder_result_checker;

    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int HALT = 2;

    logic        clk = 1'b0;
    logic        reset, start, stop, in_valid;
    logic [31:0] a, b, s;

    logic        rv  [2];
    logic        re  [2];
    logic [31:0] ec  [2];
    logic [31:0] cc  [2];
    logic [31:0] fec [2];
    logic        se  [2];
    logic [1:0]  st  [2];
    logic [31:0] fa  [2];
    logic [31:0] fb  [2];
    logic [31:0] fs  [2];

    always #5 clk = ~clk;

    adder_result_checker #(.WIDTH(32), .CNT_W(32), .HALT_ON_ERR(1'b0)) u_dut_keep (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .s(s),
        .res_valid(rv[0]), .res_err(re[0]), .err_count(ec[0]), .chk_count(cc[0]),
        .first_err_cycle(fec[0]), .sticky_err(se[0]), .state(st[0]),
        .first_err_a(fa[0]), .first_err_b(fb[0]), .first_err_s(fs[0])
    );

    adder_result_checker #(.WIDTH(32), .CNT_W(32), .HALT_ON_ERR(1'b1)) u_dut_halt (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .s(s),
        .res_valid(rv[1]), .res_err(re[1]), .err_count(ec[1]), .chk_count(cc[1]),
        .first_err_cycle(fec[1]), .sticky_err(se[1]), .state(st[1]),
        .first_err_a(fa[1]), .first_err_b(fb[1]), .first_err_s(fs[1])
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one sample can be in flight; its verdict is due at the next edge.
    bit          m_halt_mode [2] = '{1'b0, 1'b1};
    int          m_state     [2];
    bit          m_inflight  [2];
    logic [31:0] m_pa [2], m_pb [2], m_ps [2], m_pstamp [2];
    logic [31:0] m_cyc [2];
    bit          m_rv [2], m_re [2], m_sticky [2];
    logic [31:0] m_chk [2], m_err [2], m_fec [2], m_fa [2], m_fb [2], m_fs [2];

    task automatic model_edge(input int i);
        int          prev;
        bit          err;
        logic [32:0] full;
        if (reset) begin
            m_state[i] = IDLE;  m_inflight[i] = 0;  m_cyc[i] = 0;
            m_rv[i] = 0;  m_re[i] = 0;  m_sticky[i] = 0;
            m_chk[i] = 0; m_err[i] = 0; m_fec[i] = 0;
            m_fa[i] = 0;  m_fb[i] = 0;  m_fs[i] = 0;
            return;
        end
        prev  = m_state[i];
        err   = 0;
        m_rv[i] = m_inflight[i];
        if (m_inflight[i]) begin
            full = {1'b0, m_pa[i]} + {1'b0, m_pb[i]};
            err  = (full[31:0] != m_ps[i]);
            if (m_chk[i] != 32'hFFFF_FFFF) m_chk[i] = m_chk[i] + 1;
            if (err) begin
                if (m_err[i] != 32'hFFFF_FFFF) m_err[i] = m_err[i] + 1;
                if (!m_sticky[i]) begin
                    m_sticky[i] = 1;
                    m_fec[i] = m_pstamp[i];
                    m_fa[i] = m_pa[i];  m_fb[i] = m_pb[i];  m_fs[i] = m_ps[i];
                end
            end
        end
        m_re[i] = err;
        if (prev == IDLE && start && !stop) m_state[i] = RUN;
        else if (prev == RUN) begin
            if (err && m_halt_mode[i]) m_state[i] = HALT;
            else if (stop)             m_state[i] = IDLE;
        end
        m_inflight[i] = in_valid && (prev == RUN);
        if (m_inflight[i]) begin
            m_pa[i] = a;  m_pb[i] = b;  m_ps[i] = s;  m_pstamp[i] = m_cyc[i];
        end
        if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.res_valid", i), 64'(rv[i]), 64'(m_rv[i]));
            if (m_rv[i]) check($sformatf("u%0d.res_err", i), 64'(re[i]), 64'(m_re[i]));
            check($sformatf("u%0d.chk_count", i), 64'(cc[i]), 64'(m_chk[i]));
            check($sformatf("u%0d.err_count", i), 64'(ec[i]), 64'(m_err[i]));
            check($sformatf("u%0d.sticky_err", i), 64'(se[i]), 64'(m_sticky[i]));
            check($sformatf("u%0d.first_err_cycle", i), 64'(fec[i]), 64'(m_fec[i]));
            check($sformatf("u%0d.state", i), 64'(st[i]), 64'(m_state[i]));
`ifdef ADDER_CHECKER_CAPTURE_EN
            check($sformatf("u%0d.first_err_a", i), 64'(fa[i]), 64'(m_fa[i]));
            check($sformatf("u%0d.first_err_b", i), 64'(fb[i]), 64'(m_fb[i]));
            check($sformatf("u%0d.first_err_s", i), 64'(fs[i]), 64'(m_fs[i]));
`else
            check($sformatf("u%0d.first_err_a", i), 64'(fa[i]), 64'(0));
            check($sformatf("u%0d.first_err_b", i), 64'(fb[i]), 64'(0));
            check($sformatf("u%0d.first_err_s", i), 64'(fs[i]), 64'(0));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        start = 0;  stop = 0;  in_valid = 0;
    endtask

    task automatic sample(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vs);
        in_valid = 1;  a = va;  b = vb;  s = vs;
        step();
        in_valid = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    logic [31:0] wrap_s;

    initial begin
        reset = 1;  a = 0;  b = 0;  s = 0;
        quiet();

        // Reset state and first clean compare
        do_reset();
        step();
        pulse_start();
        sample(32'd3, 32'd4, 32'd7);
        step();
        check("t1.res_valid", 64'(rv[0]), 64'd1);
        check("t1.res_err", 64'(re[0]), 64'd0);
        check("t1.chk_count", 64'(cc[0]), 64'd1);
        check("t1.err_count", 64'(ec[0]), 64'd0);

        // Mismatch sampled at cycle_cnt 0x100
        for (int k = 0; k < 400 && m_cyc[0] != 32'h100; k++) step();
        check("t2.align", 64'(m_cyc[0]), 64'h100);
        sample(32'd1, 32'd2, 32'hDEAD_BEEF);
        step();
        check("t2.res_err", 64'(re[0]), 64'd1);
        check("t2.err_count", 64'(ec[0]), 64'd1);
        check("t2.sticky_err", 64'(se[0]), 64'd1);
        check("t2.first_err_cycle", 64'(fec[0]), 64'h100);
`ifdef ADDER_CHECKER_CAPTURE_EN
        check("t2.first_err_s", 64'(fs[0]), 64'hDEAD_BEEF);
`endif

        // Carry-out discarded
        wrap_s = 32'(33'h1_0000_0000);
        sample(32'hFFFF_FFFF, 32'd1, 32'd0);
        sample(32'hFFFF_FFFF, 32'd1, wrap_s);
        check("t3.wrap0.res_err", 64'(re[0]), 64'd0);
        step();
        check("t3.wrap1.res_err", 64'(re[0]), 64'd0);
        check("t3.err_count", 64'(ec[0]), 64'd1);

        // Halt-on-error with four back-to-back samples, second wrong
        do_reset();
        pulse_start();
        in_valid = 1;
        a = 32'd1; b = 32'd1; s = 32'd2; step();
        a = 32'd2; b = 32'd2; s = 32'd5; step();
        a = 32'd3; b = 32'd3; s = 32'd6; step();
        a = 32'd4; b = 32'd4; s = 32'd8; step();
        in_valid = 0;
        pulse_start();
        for (int k = 0; k < 4; k++) step();
        check("t4.halt.state", 64'(st[1]), 64'(HALT));
        check("t4.halt.chk_count", 64'(cc[1]), 64'd3);
        check("t4.halt.err_count", 64'(ec[1]), 64'd1);
        check("t4.keep.chk_count", 64'(cc[0]), 64'd4);
        check("t4.keep.state", 64'(st[0]), 64'(RUN));

        // in_valid ignored in IDLE; start+stop together
        do_reset();
        sample(32'd5, 32'd6, 32'd0);
        sample(32'd5, 32'd6, 32'd11);
        step();
        check("t5.idle.res_valid", 64'(rv[0]), 64'd0);
        check("t5.idle.chk_count", 64'(cc[0]), 64'd0);
        start = 1; stop = 1; step(); quiet();
        check("t5.idle.both", 64'(st[0]), 64'(IDLE));
        pulse_start();
        start = 1; stop = 1; step(); quiet();
        check("t5.run.both", 64'(st[0]), 64'(IDLE));

        // Reset one cycle after a sample flushes it
        do_reset();
        pulse_start();
        sample(32'd9, 32'd9, 32'd18);
        reset = 1; step(); reset = 0;
        step();
        step();
        check("t6.res_valid", 64'(rv[0]), 64'd0);
        check("t6.chk_count", 64'(cc[0]), 64'd0);
        check("t6.state", 64'(st[0]), 64'(IDLE));

        // Randomised traffic with occasional control pulses and resets
        do_reset();
        pulse_start();
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(999) < 2);
            start    = ($urandom_range(99) < 4);
            stop     = ($urandom_range(99) < 2);
            in_valid = ($urandom_range(99) < 70);
            a = ($urandom_range(9) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(9) == 0) ? 32'd1 : $urandom;
            s = a + b;
            if ($urandom_range(99) < 15) s = s ^ (32'd1 << $urandom_range(31));
            step();
        end
        quiet();
        reset = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
